// File: rtl/f1_random_delay.sv
// Random lights-out hold timer: MIN_MS + 11-bit LFSR value, counted down on the 1 ms tick.
// Define RT_MEASURE_EN to add driver reaction-time measurement and jump-start detection.
//
// state   | meaning
// IDLE    | waiting for start_delay, LFSR free-running when enabled
// RUN     | counting down the latched delay on each tick
// DONE    | delay expired, time_out high for this single cycle
// MEASURE | counting ticks until the driver presses stop (RT_MEASURE_EN)
module f1_random_delay #(
    parameter int MIN_MS = 250,
    parameter int CNT_W  = 12
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             tick,
    input  logic             en_lfsr,
    input  logic             start_delay,
`ifdef RT_MEASURE_EN
    input  logic             stop,
    output logic [CNT_W-1:0] react_ms,
    output logic             react_valid,
    output logic             jump_start,
`endif
    output logic             time_out,
    output logic             busy,
    output logic [CNT_W-1:0] delay_ms
);

    if (MIN_MS + 2047 >= 2**CNT_W) begin : g_bad_cfg
        $error("f1_random_delay: MIN_MS+2047 must be below 2**CNT_W");
    end

`ifdef RT_MEASURE_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_MEASURE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

    localparam logic [CNT_W-1:0] MIN_V = CNT_W'(MIN_MS);

    state_t           state, state_nx;
    logic [10:0]      lfsr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] start_val;
    logic             load_cnt, dec_cnt, clr_cnt;

    // Pre-step LFSR value is what gets latched, so the add sees the current register.
    assign start_val = MIN_V + CNT_W'(lfsr);

`ifdef RT_MEASURE_EN
    logic [CNT_W-1:0] react_cnt;
    logic             react_clr, react_cap, jump_nx;
`endif

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        load_cnt = 1'b0;
        dec_cnt  = 1'b0;
        clr_cnt  = 1'b0;
        time_out = 1'b0;
        busy     = 1'b1;
`ifdef RT_MEASURE_EN
        react_clr = 1'b0;
        react_cap = 1'b0;
        jump_nx   = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start_delay) begin
                    load_cnt = 1'b1;
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
`ifdef RT_MEASURE_EN
                if (stop) begin
                    jump_nx  = 1'b1;
                    clr_cnt  = 1'b1;
                    state_nx = S_IDLE;
                end else
`endif
                if (tick) begin
                    dec_cnt = 1'b1;
                    if (count == CNT_W'(1)) begin
                        state_nx = S_DONE;
                    end
                end
            end
            S_DONE: begin
                time_out = 1'b1;
`ifdef RT_MEASURE_EN
                react_clr = 1'b1;
                state_nx  = S_MEASURE;
`else
                state_nx  = S_IDLE;
`endif
            end
`ifdef RT_MEASURE_EN
            S_MEASURE: begin
                if (stop) begin
                    react_cap = 1'b1;
                    state_nx  = S_IDLE;
                end
            end
`endif
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Fibonacci x^11+x^9+1; all-zero is unreachable from the 11'h001 seed.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            lfsr     <= 11'h001;
            count    <= '0;
            delay_ms <= '0;
        end else begin
            if (en_lfsr) begin
                lfsr <= {lfsr[9:0], lfsr[10] ^ lfsr[8]};
            end
            if (load_cnt) begin
                count    <= start_val;
                delay_ms <= start_val;
            end else if (clr_cnt) begin
                count <= '0;
            end else if (dec_cnt) begin
                count <= count - CNT_W'(1);
            end
        end
    end

`ifdef RT_MEASURE_EN
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            react_cnt   <= '0;
            react_ms    <= '0;
            react_valid <= 1'b0;
            jump_start  <= 1'b0;
        end else begin
            react_valid <= react_cap;
            jump_start  <= jump_nx;
            if (react_cap) begin
                react_ms <= react_cnt;
            end
            if (react_clr) begin
                react_cnt <= '0;
            end else if (state == S_MEASURE && tick && react_cnt != '1) begin
                react_cnt <= react_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule
